timer_capture: RTL
==================

# timer_capture

Event-timestamp front end for `timer_core`. It synchronizes an asynchronous external event line and detects its active edge. It drives `timer_core`'s `TIMER_SAMPLE` strobe, then pushes the resulting 64-bit `TIMER_VALUE` into a small first-word-fall-through FIFO. Software pops timestamps as two `DATA_W` halves through the peripheral's register file.

## Interface
Parameters:
- `DATA_W`, 32, word width; a timestamp is `2*DATA_W` bits.
- `FIFO_ADDR_W`, 2, log2 of FIFO depth (default depth 4).
- `SYNC_STAGES`, 2, flip-flops in the `event_in` synchronizer (minimum 2).

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `event_in`  in  1  asynchronous event line.
- `TIMER_VALUE`  in  `2*DATA_W`  sampled count from `timer_core`.
- `TIMER_SAMPLE`  out  1  one-cycle strobe to `timer_core`.
- `CAPT_POP`  in  1  one-cycle pulse; discards the FIFO head.
- `CAPT_CLR`  in  1  one-cycle pulse; flushes the FIFO and clears `CAPT_OVERFLOW`.
- `CAPT_DATA_LOW`  out  `DATA_W`  head timestamp, bits `[DATA_W-1:0]`.
- `CAPT_DATA_HIGH`  out  `DATA_W`  head timestamp, bits `[2*DATA_W-1:DATA_W]`.
- `CAPT_EMPTY`  out  1  FIFO empty.
- `CAPT_FULL`  out  1  FIFO full.
- `CAPT_LEVEL`  out  `FIFO_ADDR_W+1`  number of stored entries.
- `CAPT_OVERFLOW`  out  1  sticky flag: a timestamp was dropped.

## Operation
- Synchronizer: `event_in` passes through a `SYNC_STAGES` flip-flop chain. A further register holds the previous synced value for edge detection.
- Edge detect: `edge` is asserted when the synced value is 1 and the previous value is 0 (rising edge only in the base build).
- Strobe: `TIMER_SAMPLE` is `edge` registered. It is high for exactly one cycle per detected edge.
- Push: `push` is `TIMER_SAMPLE` delayed by one register. On a `push` cycle, `TIMER_VALUE` holds the newly sampled count and is written at the FIFO tail. This stage is a pure pipeline with no FSM, so back-to-back strobes produce back-to-back pushes.
- FIFO storage: `2^FIFO_ADDR_W` entries, each `2*DATA_W` bits wide.
- FIFO pointers: read and write pointers are `FIFO_ADDR_W` bits and wrap modulo depth. The level counter is `FIFO_ADDR_W+1` bits.
- Outputs: `CAPT_DATA_*` show the head entry combinationally from storage and read 0 while `CAPT_EMPTY` is set.
- Push while full, no pop: the new timestamp is dropped, `CAPT_OVERFLOW` is set, and stored entries are unchanged.
- Push and pop in the same cycle:
  - When not empty, both take effect and the level is unchanged.
  - When full, this is not an overflow.
  - When empty, the pop is ignored and the push takes effect.
- Pop while empty: ignored; pointers and level do not change.
- `CAPT_CLR`:
  - Sets pointers and level to 0 and clears `CAPT_OVERFLOW`.
  - Takes priority over a same-cycle push or pop; that push is lost and does not set overflow.
  - Edges already in the sync/strobe pipeline continue and push after the clear.
- Gated timer: the timestamp is whatever `timer_core` holds. If `TIMER_ENABLE` is low, repeated events capture the same value.

## Timing
- Reset values:
  - `TIMER_SAMPLE` = 0, `CAPT_EMPTY` = 1, `CAPT_FULL` = 0, `CAPT_LEVEL` = 0, `CAPT_OVERFLOW` = 0, `CAPT_DATA_*` = 0.
  - All synchronizer and edge registers = 0, so a line already high at reset release produces one rising edge.
- Latency, with E the first cycle the synchronizer output shows the new level:
  - `TIMER_SAMPLE` is high in cycle E+1.
  - `timer_core` latches at the end of E+1.
  - `push` occurs in cycle E+2.
  - `CAPT_EMPTY`, `CAPT_LEVEL` and `CAPT_DATA_*` update in E+3.
- Input latency: `event_in` to E is `SYNC_STAGES` to `SYNC_STAGES`+1 cycles.
- Pop timing: a pop in cycle P updates the head, level and flags in P+1.
- Throughput: one capture per cycle.
- Minimum event spacing: two cycles in the base build (high one cycle, low one cycle).
- Mid-operation reset: asynchronously clears everything; in-flight edges are lost.

## Configuration
- Macro: `TIMER_CAPTURE_BOTHEDGES_EN`.
- Defined: `edge` = synced value XOR previous value, so rising and falling edges are both timestamped. An input toggling every cycle yields one strobe and one push per cycle.
- Undefined: rising edges only; falling edges are ignored.

## Test plan
- Single event: counter free-running from reset, `event_in` rises once → exactly one `TIMER_SAMPLE` pulse. `CAPT_LEVEL` becomes 1 and `CAPT_DATA_LOW` equals the count captured at the strobe; `CAPT_DATA_HIGH` = 0.
- High-word capture: counter preloaded near 0x0000_0000_FFFF_FFFF, event fired → `CAPT_DATA_HIGH` = 1, `CAPT_DATA_LOW` = the low 32 bits of the captured count.
- Fill and overflow: 5 rising edges with no pop at depth 4 → `CAPT_FULL` = 1, `CAPT_LEVEL` = 4, `CAPT_OVERFLOW` = 1. Popping 4 times returns the first four timestamps in order, then `CAPT_EMPTY` = 1.
- Simultaneous operations:
  - Push and pop in the same cycle while full → level stays 4 and `CAPT_OVERFLOW` stays 0.
  - Pop while empty → no change.
  - `CAPT_CLR` with a same-cycle push → level 0 and overflow 0.
- Both-edge build: with `TIMER_CAPTURE_BOTHEDGES_EN` defined, `event_in` toggled every cycle for 4 cycles → 4 consecutive strobes and 4 entries. Base build with the same stimulus → 2 entries.
- Reset mid-operation: `rst` asserted with 3 entries stored and one edge in flight → all outputs return to reset values immediately, and no push occurs after release.

Source files
------------

// File: rtl/timer_capture.sv
// Event timestamp capture: synchronizes event_in, strobes timer_core and queues 64-bit counts.
// Optional build macro TIMER_CAPTURE_BOTHEDGES_EN timestamps falling edges as well.
module timer_capture #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned FIFO_ADDR_W = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   event_in,
  input  logic [2*DATA_W-1:0]    TIMER_VALUE,
  output logic                   TIMER_SAMPLE,
  input  logic                   CAPT_POP,
  input  logic                   CAPT_CLR,
  output logic [DATA_W-1:0]      CAPT_DATA_LOW,
  output logic [DATA_W-1:0]      CAPT_DATA_HIGH,
  output logic                   CAPT_EMPTY,
  output logic                   CAPT_FULL,
  output logic [FIFO_ADDR_W:0]   CAPT_LEVEL,
  output logic                   CAPT_OVERFLOW
);

  localparam int unsigned Depth = 1 << FIFO_ADDR_W;
  localparam int unsigned TsW   = 2 * DATA_W;
  localparam logic [FIFO_ADDR_W:0] FullLevel = {1'b1, {FIFO_ADDR_W{1'b0}}};

  // Event synchronizer and edge detector
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   prev_q;
  logic                   edge_det;
  logic                   sample_q;
  logic                   push_q;

  assign synced = sync_q[SYNC_STAGES-1];

`ifdef TIMER_CAPTURE_BOTHEDGES_EN
  assign edge_det = synced ^ prev_q;
`else
  assign edge_det = synced & ~prev_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      sample_q <= 1'b0;
      push_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], event_in};
      prev_q   <= synced;
      sample_q <= edge_det;
      // timer_core presents the latched count one cycle after the strobe
      push_q   <= sample_q;
    end
  end

  assign TIMER_SAMPLE = sample_q;

  // Timestamp FIFO
  logic [TsW-1:0]         mem [Depth];
  logic [FIFO_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_ADDR_W:0]   level_q, level_d;
  logic                   overflow_q, overflow_d;
  logic                   empty;
  logic                   full;
  logic                   pop_ok;
  logic                   push_ok;
  logic                   wr_en;
  logic [TsW-1:0]         head;

  assign empty = (level_q == '0);
  assign full  = (level_q == FullLevel);

  // A pop frees the head slot in the same cycle, so a full FIFO still accepts the push
  assign pop_ok  = CAPT_POP & ~empty;
  assign push_ok = push_q & (~full | pop_ok);
  assign wr_en   = push_ok & ~CAPT_CLR;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (CAPT_CLR) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      if (push_q && !push_ok) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the head is masked while empty
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= TIMER_VALUE;
    end
  end

  assign head = empty ? '0 : mem[rd_ptr_q];

  assign CAPT_DATA_LOW  = head[DATA_W-1:0];
  assign CAPT_DATA_HIGH = head[TsW-1:DATA_W];
  assign CAPT_EMPTY     = empty;
  assign CAPT_FULL      = full;
  assign CAPT_LEVEL     = level_q;
  assign CAPT_OVERFLOW  = overflow_q;

endmodule
